clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Sits directly downstream of clk_div_4. Samples its clk_4 output as a data signal in the source clk domain.
- Checks the divided clock's high/low run lengths against the expected ratio and reports lock and error status.
- Emits a one-cycle enable pulse per divided-clock rising edge for downstream logic.

Parameters:
DIV, 4, expected divide ratio; must be even and >= 2; HALF = DIV/2
LOCK_CNT, 4, consecutive good periods required to assert locked; must be >= 1
CNT_W, 8, width of run counter and hi_len/lo_len; saturating
ERR_CNT_W, 8, width of err_cnt; saturating

Ports:
clk  in  1  system clock; same clock that drives clk_div_4
rst  in  1  synchronous, active-low reset
clk_div_in  in  1  divided clock (clk_4), synchronous to clk
enable  in  1  monitor enable; 0 forces IDLE
clear  in  1  one-cycle pulse; clears err and err_cnt
rise_pulse  out  1  one-cycle pulse per detected rising edge of clk_div_in
locked  out  1  1 while in LOCK state
err  out  1  sticky error flag
err_cnt  out  ERR_CNT_W  number of error events, saturating
hi_len  out  CNT_W  length of last completed high run, in clk cycles
lo_len  out  CNT_W  length of last completed low run, in clk cycles

Behaviour:
- Reset (rst==0 at a clk edge): every output is 0; state is IDLE; s1, s2, run_cnt and good_cnt are 0.
- Sampling: s1 <= clk_div_in; s2 <= s1.
  - rise = s1 & ~s2; fall = ~s1 & s2 (both combinational).
  - rise_pulse <= rise & enable.
  - Latency: input first sampled high at edge N gives rise_pulse=1 after edge N+1.
- FSM is updated on rise/fall in the same cycle; locked = (state==LOCK).
- IDLE: hold hi_len, lo_len, err and err_cnt. enable=1 moves to ACQ.
- ACQ:
  - Discard any partial run.
  - On rise: go to MEAS, run_cnt=1, good_cnt=0.
  - No errors are flagged in ACQ.
- MEAS and LOCK share the same checks:
  - No edge: run_cnt++ (saturating at 2^CNT_W-1).
  - On fall: hi_len <= run_cnt. If run_cnt != HALF, raise an error event.
  - On rise: lo_len <= run_cnt. If run_cnt != HALF, raise an error event. Otherwise, in MEAS, good_cnt++; if good_cnt+1 == LOCK_CNT, go to LOCK.
  - On any edge, run_cnt restarts at 1.
  - A period is good only if the preceding high run was also good. A bad high run already forces ACQ, so no extra tracking is needed.
- Error event:
  - err <= 1; err_cnt <= err_cnt+1, saturating at all-ones.
  - State goes to ACQ, so locked drops the next cycle; good_cnt <= 0.
- enable=0 in any state: go to IDLE next cycle; locked=0; hi_len, lo_len, err and err_cnt hold.
- clear: err <= 0, err_cnt <= 0. If an error event occurs in the same cycle, the error wins over clear: err=1, err_cnt=1.
- Lock timing with DIV=4, LOCK_CNT=4: locked rises in the same cycle as the 5th rise_pulse, 16 clk cycles after the 1st.
- Reset mid-operation: immediate return to the full reset state; no partial results are kept.

Optional Feature:
CLK_DIV_MON_STUCK_EN
- Defined: in MEAS or LOCK, if there is no edge this cycle and run_cnt == HALF, raise an error event. A stuck or slow input is flagged on the first cycle its run would exceed HALF.
- Not defined: errors are detected only at edges. A stuck input leaves the monitor in MEAS/LOCK with no error and locked unchanged.

Test Plan:
1. Reset: rst=0 for 3 cycles with random inputs -> all outputs 0. After release with enable=0, outputs stay 0.
2. Lock acquisition: clk_div_in = ideal clk_4 (2 high / 2 low), enable=1, DIV=4, LOCK_CNT=4.
   - rise_pulse every 4 cycles.
   - hi_len=2, lo_len=2.
   - locked=1 with the 5th rise_pulse; err=0.
3. Bad run: after lock, stretch one high run to 3 cycles.
   - On that fall: hi_len=3, err=1, err_cnt=1.
   - locked=0 on the next cycle.
   - Relocks on the 5th rise_pulse after re-entry to MEAS.
4. Stuck (macro on): after lock, hold clk_div_in=1.
   - Error event on the 3rd high cycle: err_cnt=1, locked drops.
   - err_cnt stays 1 while the input is stuck.
   - With the macro off: no error and locked stays 1.
5. Clear: with err_cnt=3, pulse clear -> err=0, err_cnt=0. Clear coinciding with a bad-edge error -> err=1, err_cnt=1.
6. Enable and reset mid-run:
   - Drop enable while locked -> locked=0 the next cycle; hi_len, lo_len and err_cnt hold.
   - Re-enable -> relocks after 5 rise_pulses.
   - Assert rst mid-MEAS -> all outputs 0.

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// Monitor-side bundle for clk_div_monitor: divided-clock sample, controls and status.
// Monitor (slave) consumes clk_div_in/enable/clear and drives status; master is the driver side.
interface clk_div_monitor_if #(
  parameter int CNT_W     = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 clk_div_in;
  logic                 enable;
  logic                 clear;
  logic                 rise_pulse;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0]     hi_len;
  logic [CNT_W-1:0]     lo_len;

  modport master (
    output clk_div_in, enable, clear,
    input  rise_pulse, locked, err, err_cnt, hi_len, lo_len
  );

  modport slave (
    input  clk_div_in, enable, clear,
    output rise_pulse, locked, err, err_cnt, hi_len, lo_len
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Checks clk_div_in high/low run lengths, reports lock/error; CLK_DIV_MON_STUCK_EN adds stuck-input detect.
// Latency: rise_pulse 2 clk after the input rises; no backpressure, free-running monitor.
module clk_div_monitor #(
  parameter int DIV       = 4,
  parameter int LOCK_CNT  = 4,
  parameter int CNT_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  clk_div_monitor_if.slave mon
);

  localparam int HALF = DIV / 2;
  localparam int GC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(HALF);
  localparam logic [GC_W-1:0]  LAST_GC  = GC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_t;

  state_t               state;
  logic                 s1, s2;
  logic [CNT_W-1:0]     run_cnt;
  logic [GC_W-1:0]      good_cnt;
  logic                 rise_pulse;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0]     hi_len;
  logic [CNT_W-1:0]     lo_len;

  logic rise, fall, in_meas, edge_err, stuck_err, err_evt;

  assign rise     = s1 & ~s2;
  assign fall     = ~s1 & s2;
  assign in_meas  = (state == MEAS) || (state == LOCK);
  assign edge_err = (rise || fall) && (run_cnt != HALF_C);

`ifdef CLK_DIV_MON_STUCK_EN
  // A run already at HALF with no edge this cycle is about to overrun.
  assign stuck_err = !rise && !fall && (run_cnt == HALF_C);
`else
  assign stuck_err = 1'b0;
`endif

  assign err_evt = mon.enable && in_meas && (edge_err || stuck_err);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      run_cnt    <= '0;
      good_cnt   <= '0;
      rise_pulse <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      hi_len     <= '0;
      lo_len     <= '0;
    end else begin
      s1         <= mon.clk_div_in;
      s2         <= s1;
      rise_pulse <= rise & mon.enable;

      // An error event in the same cycle as clear wins and restarts the count at 1.
      if (err_evt) begin
        err     <= 1'b1;
        err_cnt <= mon.clear ? ERR_CNT_W'(1)
                 : (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);
      end else if (mon.clear) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end

      if (!mon.enable) begin
        state    <= IDLE;
        locked   <= 1'b0;
        run_cnt  <= '0;
        good_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ACQ;
            locked   <= 1'b0;
            run_cnt  <= '0;
            good_cnt <= '0;
          end
          ACQ: begin
            good_cnt <= '0;
            if (rise) begin
              state   <= MEAS;
              run_cnt <= CNT_W'(1);
            end else begin
              run_cnt <= '0;
            end
          end
          MEAS, LOCK: begin
            if (fall) hi_len <= run_cnt;
            if (rise) lo_len <= run_cnt;

            if (rise || fall)
              run_cnt <= CNT_W'(1);
            else if (run_cnt != '1)
              run_cnt <= run_cnt + CNT_W'(1);

            // A bad high run already dropped us to ACQ, so a good rise implies a good period.
            if (err_evt) begin
              state    <= ACQ;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else if (rise && state == MEAS) begin
              good_cnt <= good_cnt + GC_W'(1);
              if (good_cnt == LAST_GC) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.rise_pulse = rise_pulse;
  assign mon.locked     = locked;
  assign mon.err        = err;
  assign mon.err_cnt    = err_cnt;
  assign mon.hi_len     = hi_len;
  assign mon.lo_len     = lo_len;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor (DIV=4, LOCK_CNT=4); rise_pulse timing tracked by an expected-cycle queue.
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clk_div_monitor_if #(.CNT_W(8), .ERR_CNT_W(8)) mon ();

  clk_div_monitor #(
    .DIV(4), .LOCK_CNT(4), .CNT_W(8), .ERR_CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   first_pulse = -1;
  int   exp_q[$];
  logic prev_din = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Drive one input sample, advance one clk, then score rise_pulse against the queue.
  task automatic tick(input logic din);
    logic exp_pulse;
    mon.clk_div_in = din;
    if (!rst) begin
      exp_q.delete();
      prev_din = 1'b0;
    end else begin
      if (mon.enable && din && !prev_din) exp_q.push_back(cyc + 2);
      prev_din = din;
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_pulse = (exp_q.size() > 0) && (exp_q[0] == cyc);
    chk("rise_pulse", {31'd0, mon.rise_pulse}, {31'd0, exp_pulse});
    if (exp_pulse) void'(exp_q.pop_front());
    if (mon.rise_pulse && first_pulse < 0) first_pulse = cyc;
  endtask

  task automatic period(input int hi, input int lo);
    repeat (hi) tick(1'b1);
    repeat (lo) tick(1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, mon.locked}, 0);
    chk({tag, "_err"},    {31'd0, mon.err}, 0);
    chk({tag, "_errcnt"}, {24'd0, mon.err_cnt}, 0);
    chk({tag, "_hilen"},  {24'd0, mon.hi_len}, 0);
    chk({tag, "_lolen"},  {24'd0, mon.lo_len}, 0);
  endtask

  initial begin
    mon.clk_div_in = 1'b0;
    mon.enable     = 1'b0;
    mon.clear      = 1'b0;

    // Reset with random inputs, then idle with enable low
    rst = 1'b0;
    repeat (3) begin
      mon.enable = 1'($urandom_range(0, 1));
      mon.clear  = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)));
      chk_zero("reset");
    end
    rst = 1'b1;
    mon.enable = 1'b0;
    mon.clear  = 1'b0;
    period(1, 1);
    period(1, 1);
    chk_zero("idle");

    // Lock acquisition on an ideal divide-by-4 input
    mon.enable = 1'b1;
    tick(1'b0);
    tick(1'b0);
    repeat (4) period(2, 2);
    chk("lock_pre4", {31'd0, mon.locked}, 0);
    chk("err_pre4", {31'd0, mon.err}, 0);
    tick(1'b1);
    chk("lock_before5", {31'd0, mon.locked}, 0);
    tick(1'b1);
    chk("lock_at5", {31'd0, mon.locked}, 1);
    chk("lock_dist", 32'(cyc - first_pulse), 16);
    tick(1'b0);
    tick(1'b0);
    chk("hi_len_ideal", {24'd0, mon.hi_len}, 2);
    chk("lo_len_ideal", {24'd0, mon.lo_len}, 2);
    chk("err_ideal", {31'd0, mon.err}, 0);
    chk("errcnt_ideal", {24'd0, mon.err_cnt}, 0);

    // Stretched high run after lock
    repeat (3) tick(1'b1);
    tick(1'b0);
    chk("bad_lock_hold", {31'd0, mon.locked}, 1);
    chk("bad_err_pre", {31'd0, mon.err}, 0);
    tick(1'b0);
    chk("bad_hi_len", {24'd0, mon.hi_len}, 3);
    chk("bad_err", {31'd0, mon.err}, 1);
    chk("bad_errcnt", {24'd0, mon.err_cnt}, 1);
    chk("bad_unlock", {31'd0, mon.locked}, 0);
    repeat (4) period(2, 2);
    chk("relock_pre", {31'd0, mon.locked}, 0);
    period(2, 2);
    chk("relock", {31'd0, mon.locked}, 1);
    chk("relock_errcnt", {24'd0, mon.err_cnt}, 1);

    // Clear on the next rise, then hold the input high
    mon.clear = 1'b1;
    tick(1'b1);
    mon.clear = 1'b0;
    chk("clear_err", {31'd0, mon.err}, 0);
    chk("clear_errcnt", {24'd0, mon.err_cnt}, 0);
    tick(1'b1);
    tick(1'b1);
    chk("stuck_pre_errcnt", {24'd0, mon.err_cnt}, 0);
    chk("stuck_pre_lock", {31'd0, mon.locked}, 1);
    tick(1'b1);
`ifdef CLK_DIV_MON_STUCK_EN
    chk("stuck_errcnt", {24'd0, mon.err_cnt}, 1);
    chk("stuck_err", {31'd0, mon.err}, 1);
    chk("stuck_unlock", {31'd0, mon.locked}, 0);
    repeat (10) tick(1'b1);
    chk("stuck_errcnt_hold", {24'd0, mon.err_cnt}, 1);
    chk("stuck_unlock_hold", {31'd0, mon.locked}, 0);
`else
    chk("nostuck_errcnt", {24'd0, mon.err_cnt}, 0);
    chk("nostuck_lock", {31'd0, mon.locked}, 1);
    repeat (10) tick(1'b1);
    chk("nostuck_errcnt_hold", {24'd0, mon.err_cnt}, 0);
    chk("nostuck_err_hold", {31'd0, mon.err}, 0);
    chk("nostuck_lock_hold", {31'd0, mon.locked}, 1);
`endif
    tick(1'b0);
    tick(1'b0);
`ifdef CLK_DIV_MON_STUCK_EN
    chk("after_stuck_hi_len", {24'd0, mon.hi_len}, 2);
`else
    chk("after_stuck_hi_len", {24'd0, mon.hi_len}, 14);
`endif
    chk("after_stuck_errcnt", {24'd0, mon.err_cnt}, 1);
    chk("after_stuck_lock", {31'd0, mon.locked}, 0);

    // Accumulate to three errors, clear, then clear colliding with an error
    period(2, 2);
    period(3, 2);
    period(2, 2);
    period(3, 2);
    chk("errcnt_3", {24'd0, mon.err_cnt}, 3);
    mon.clear = 1'b1;
    tick(1'b0);
    mon.clear = 1'b0;
    chk("clear3_err", {31'd0, mon.err}, 0);
    chk("clear3_errcnt", {24'd0, mon.err_cnt}, 0);
    period(2, 2);
    period(3, 2);
    chk("errcnt_1", {24'd0, mon.err_cnt}, 1);
    period(2, 2);
    repeat (3) tick(1'b1);
    tick(1'b0);
    mon.clear = 1'b1;
    tick(1'b0);
    mon.clear = 1'b0;
    chk("clr_vs_err_err", {31'd0, mon.err}, 1);
    chk("clr_vs_err_cnt", {24'd0, mon.err_cnt}, 1);

    // Enable drop while locked, then re-enable
    repeat (5) period(2, 2);
    chk("en_lock", {31'd0, mon.locked}, 1);
    mon.enable = 1'b0;
    tick(1'b0);
    chk("dis_unlock", {31'd0, mon.locked}, 0);
    period(3, 1);
    tick(1'b0);
    chk("dis_hi_len", {24'd0, mon.hi_len}, 2);
    chk("dis_lo_len", {24'd0, mon.lo_len}, 2);
    chk("dis_errcnt", {24'd0, mon.err_cnt}, 1);
    chk("dis_lock", {31'd0, mon.locked}, 0);
    mon.enable = 1'b1;
    tick(1'b0);
    tick(1'b0);
    repeat (4) period(2, 2);
    chk("reen_pre", {31'd0, mon.locked}, 0);
    period(2, 2);
    chk("reen_lock", {31'd0, mon.locked}, 1);

    // Reset in the middle of a MEAS high run
    period(3, 2);
    chk("pre_rst_errcnt", {24'd0, mon.err_cnt}, 2);
    period(2, 2);
    tick(1'b1);
    rst = 1'b0;
    tick(1'b1);
    chk_zero("midrst");
    rst = 1'b1;
    mon.enable = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk_zero("post_rst");

    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
